sdram_init_sequencer: RTL and testbench

//  Drives the JEDEC power-up command sequence onto the SDRAM pins:

---
 rtl/sdram_cmd_pkg.sv | 39 +++
 rtl/sdram_wait_counter.sv | 32 +++
 rtl/sdram_init_sequencer.sv | 129 ++++++++++++
 tb/tb_sdram_init_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_cmd_pkg: SDRAM command encodings and init-sequencer states.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sdram_cmd_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_NOP = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_PWR  = 3'd0,
    ST_PRE  = 3'd1,
    ST_WRP  = 3'd2,
    ST_REF  = 3'd3,
    ST_WRFC = 3'd4,
    ST_LMR  = 3'd5,
    ST_WMRD = 3'd6,
    ST_DONE = 3'd7
  } init_state_e;

  localparam int A10 = 10;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_wait_counter: loadable down-counter that saturates at zero.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sdram_wait_counter #(
  parameter int             W       = 10,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_init_sequencer: JEDEC power-up sequence (PWR wait, PRECHARGE-   |
// | ALL, N x AUTO-REFRESH, LOAD-MODE) with re-init on request. Rev 1.0    |
// +----------------------------------------------------------------------+
module sdram_init_sequencer
  import sdram_cmd_pkg::*;
#(
  parameter int T_PWR   = 505,
  parameter int T_RP    = 2,
  parameter int T_RFC   = 7,
  parameter int NUM_REF = 2,
  parameter int T_MRD   = 9,
  parameter int AW      = 13
) (
  input  logic          sdram_clk,
  input  logic          sdram_resetn,
  input  logic [AW-1:0] cfg_mode_reg,
  input  logic          init_req,
  output logic          sdr_cke,
  output logic          sdr_cs_n,
  output logic          sdr_ras_n,
  output logic          sdr_cas_n,
  output logic          sdr_we_n,
  output logic [1:0]    sdr_ba,
  output logic [AW-1:0] sdr_addr,
  output logic          sdr_init_done
);

  localparam int CW = $clog2(max_of4(T_PWR, T_RP, T_RFC, T_MRD)) + 1;
  localparam int RW = $clog2(NUM_REF + 1);

  init_state_e   state;
  init_state_e   state_nxt;
  logic [RW-1:0] ref_cnt;
  logic          cnt_load;
  logic [CW-1:0] cnt_value;
  logic          cnt_zero;
  sdram_cmd_e    cmd_nxt;
  logic [AW-1:0] addr_nxt;

  sdram_wait_counter #(
    .W       (CW),
    .RST_VAL (CW'(T_PWR - 1))
  ) u_wait_counter (
    .clk   (sdram_clk),
    .rst_n (sdram_resetn),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ST_PWR:  if (cnt_zero) state_nxt = ST_PRE;
      ST_PRE: begin
        state_nxt = ST_WRP;
        cnt_load  = 1'b1;
        cnt_value = CW'(T_RP - 1);
      end
      ST_WRP:  if (cnt_zero) state_nxt = ST_REF;
      ST_REF: begin
        state_nxt = ST_WRFC;
        cnt_load  = 1'b1;
        cnt_value = CW'(T_RFC - 1);
      end
      ST_WRFC: if (cnt_zero) state_nxt = (ref_cnt < RW'(NUM_REF)) ? ST_REF : ST_LMR;
      ST_LMR: begin
        state_nxt = ST_WMRD;
        cnt_load  = 1'b1;
        cnt_value = CW'(T_MRD - 1);
      end
      ST_WMRD: if (cnt_zero) state_nxt = ST_DONE;
      ST_DONE: if (init_req) state_nxt = ST_PRE;
      default: state_nxt = ST_PWR;
    endcase
  end

  // Bus is a registered decode of the current state, so commands trail state entry by one cycle.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    case (state)
      ST_PRE: begin
        cmd_nxt       = CMD_PRE;
        addr_nxt[A10] = 1'b1;
      end
      ST_REF:  cmd_nxt = CMD_REF;
      ST_LMR: begin
        cmd_nxt  = CMD_LMR;
        addr_nxt = cfg_mode_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state         <= ST_PWR;
      ref_cnt       <= '0;
      sdr_cke       <= 1'b0;
      sdr_cs_n      <= 1'b1;
      sdr_ras_n     <= 1'b1;
      sdr_cas_n     <= 1'b1;
      sdr_we_n      <= 1'b1;
      sdr_ba        <= 2'b00;
      sdr_addr      <= '0;
      sdr_init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_PRE) begin
        ref_cnt <= '0;
      end else if (state == ST_REF) begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      sdr_cke                                   <= 1'b1;
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_nxt;
      sdr_ba                                    <= 2'b00;
      sdr_addr                                  <= addr_nxt;
      // Drop done in the same cycle the re-init request is accepted.
      sdr_init_done                             <= (state == ST_DONE) && !init_req;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_init_sequencer: scoreboard bench for default and minimal-    |
// | timing sequencers. Rev 1.0                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sdram_init_sequencer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  typedef struct packed {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        done;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_req = 1'b0;
  logic        init_req_b = 1'b0;
  logic [12:0] cfg = 13'h1FF;

  logic        cke_a, cs_a, ras_a, cas_a, we_a, done_a;
  logic [1:0]  ba_a;
  logic [12:0] addr_a;
  logic        cke_b, cs_b, ras_b, cas_b, we_b, done_b;
  logic [1:0]  ba_b;
  logic [12:0] addr_b;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc;
  logic prev_done_a = 1'b0, prev_done_b = 1'b0, cke_bad_a = 1'b0, lmr_seen_b = 1'b0;

  always #5 clk = ~clk;

  sdram_init_sequencer u_dut_a (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_mode_reg(cfg), .init_req(init_req),
    .sdr_cke(cke_a), .sdr_cs_n(cs_a), .sdr_ras_n(ras_a), .sdr_cas_n(cas_a), .sdr_we_n(we_a),
    .sdr_ba(ba_a), .sdr_addr(addr_a), .sdr_init_done(done_a)
  );

  sdram_init_sequencer #(
    .T_PWR(4), .T_RP(1), .T_RFC(1), .NUM_REF(1), .T_MRD(1), .AW(13)
  ) u_dut_b (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_mode_reg(cfg), .init_req(init_req_b),
    .sdr_cke(cke_b), .sdr_cs_n(cs_b), .sdr_ras_n(ras_b), .sdr_cas_n(cas_b), .sdr_we_n(we_b),
    .sdr_ba(ba_b), .sdr_addr(addr_b), .sdr_init_done(done_b)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  task automatic cmp_ev(input string who, input ev_t exp, input ev_t act);
    checks++;
    if (exp != act) begin
      errors++;
      $display("FAIL %s: actual cyc=%0d cmd=%b addr=%h ba=%0d done=%b, required cyc=%0d cmd=%b addr=%h ba=%0d done=%b",
               who, act.cyc, act.cmd, act.addr, act.ba, act.done,
               exp.cyc, exp.cmd, exp.addr, exp.ba, exp.done);
    end
  endtask

  task automatic cmp_int(input string who, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", who, act, exp);
    end
  endtask

  task automatic check_reset(input string who);
    cmp_int({who, "_a"}, int'({cke_a, cs_a, ras_a, cas_a, we_a, ba_a, addr_a, done_a}), int'(21'h0F_0000));
    cmp_int({who, "_b"}, int'({cke_b, cs_b, ras_b, cas_b, we_b, ba_b, addr_b, done_b}), int'(21'h0F_0000));
  endtask

  function automatic ev_t mk(input int c, input logic [3:0] cmd, input logic [12:0] addr, input logic done);
    ev_t e;
    e.cyc = c; e.cmd = cmd; e.addr = addr; e.ba = 2'b00; e.done = done;
    return e;
  endfunction

  task automatic push_a_full(input logic [12:0] lmr_addr);
    qa.push_back(mk(505, PRE, 13'h400, 1'b0));
    qa.push_back(mk(508, REF, 13'h000, 1'b0));
    qa.push_back(mk(516, REF, 13'h000, 1'b0));
    qa.push_back(mk(524, LMR, lmr_addr, 1'b0));
    qa.push_back(mk(534, NOP, 13'h000, 1'b1));
  endtask

  task automatic push_b_full();
    qb.push_back(mk(4,  PRE, 13'h400, 1'b0));
    qb.push_back(mk(6,  REF, 13'h000, 1'b0));
    qb.push_back(mk(8,  LMR, 13'h1FF, 1'b0));
    qb.push_back(mk(10, NOP, 13'h000, 1'b1));
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: any non-NOP command or init_done edge is an event to be matched.
  always @(negedge clk) begin
    if (!rst_n || cyc < 0) begin
      prev_done_a = 1'b0;
      prev_done_b = 1'b0;
      lmr_seen_b  = 1'b0;
    end else begin
      if (cke_a !== 1'b1) cke_bad_a = 1'b1;
      if ({cs_a, ras_a, cas_a, we_a} != NOP || done_a != prev_done_a) begin
        if (qa.size() == 0) cmp_ev("dut_a_unexpected", mk(-1, NOP, 13'h0, prev_done_a),
                                   mk(cyc, {cs_a, ras_a, cas_a, we_a}, addr_a, done_a));
        else cmp_ev("dut_a_event", qa.pop_front(),
                    {cyc, {cs_a, ras_a, cas_a, we_a}, addr_a, ba_a, done_a});
      end
      if ({cs_b, ras_b, cas_b, we_b} != NOP || done_b != prev_done_b) begin
        if (qb.size() == 0) cmp_ev("dut_b_unexpected", mk(-1, NOP, 13'h0, prev_done_b),
                                   mk(cyc, {cs_b, ras_b, cas_b, we_b}, addr_b, done_b));
        else cmp_ev("dut_b_event", qb.pop_front(),
                    {cyc, {cs_b, ras_b, cas_b, we_b}, addr_b, ba_b, done_b});
        if ({cs_b, ras_b, cas_b, we_b} == PRE) lmr_seen_b = 1'b0;
        if ({cs_b, ras_b, cas_b, we_b} == LMR) lmr_seen_b = 1'b1;
        if (done_b && !prev_done_b) cmp_int("dut_b_done_after_lmr", int'(lmr_seen_b), 1);
      end
      prev_done_a = done_a;
      prev_done_b = done_b;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("por");

    // Defaults, mode-register isolation, and ignored init_req outside DONE
    push_a_full(13'h033);
    push_b_full();
    rst_n = 1'b1;
    to_cycle(299); init_req = 1'b1;
    to_cycle(300); init_req = 1'b0;
    to_cycle(511); init_req = 1'b1;
    to_cycle(512); init_req = 1'b0;
    to_cycle(523); cfg = 13'h033;
    to_cycle(524); cfg = 13'h1FF;
    to_cycle(540);
    cmp_int("seq1_a_pending", qa.size(), 0);
    cmp_int("seq1_b_pending", qb.size(), 0);

    // Re-init from DONE
    init_req = 1'b1;
    qa.push_back(mk(541, NOP, 13'h000, 1'b0));
    qa.push_back(mk(542, PRE, 13'h400, 1'b0));
    qa.push_back(mk(545, REF, 13'h000, 1'b0));
    qa.push_back(mk(553, REF, 13'h000, 1'b0));
    qa.push_back(mk(561, LMR, 13'h1FF, 1'b0));
    qa.push_back(mk(571, NOP, 13'h000, 1'b1));
    to_cycle(541); init_req = 1'b0;
    to_cycle(580);
    cmp_int("reinit_a_pending", qa.size(), 0);
    cmp_int("cke_never_dropped", int'(cke_bad_a), 0);

    // Async reset while DONE, then mid-sequence at cycle 510
    #2 rst_n = 1'b0;
    #1 check_reset("async_done");
    repeat (3) @(negedge clk);
    qa.push_back(mk(505, PRE, 13'h400, 1'b0));
    qa.push_back(mk(508, REF, 13'h000, 1'b0));
    push_b_full();
    rst_n = 1'b1;
    to_cycle(510);
    #2 rst_n = 1'b0;
    #1 check_reset("async_510");
    cmp_int("pre_reset_a_pending", qa.size(), 0);
    repeat (10) @(negedge clk);
    push_a_full(13'h1FF);
    push_b_full();
    rst_n = 1'b1;
    to_cycle(540);
    cmp_int("restart_a_pending", qa.size(), 0);
    cmp_int("restart_b_pending", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
